// File: rtl/sam_video_address.sv
// SAM video address generator: follows VDG DA0/HS_n/FS_n to produce the display fetch address VA.
// Build option SAM_EXT_VIDEO_EN: V[3]=1 selects extended linear mode with 256-byte base granularity.
module sam_video_address #(
  parameter int DIV_W = 4
) (
  input  logic             clk,
  input  logic             RESET,
  input  logic             DA0,
  input  logic             HS_n,
  input  logic             FS_n,
  input  logic [3:0]       V,
  input  logic [7:0]       F,
  output logic [15:0]      VA,
  output logic             ROW_ADV,
  output logic [DIV_W-1:0] LINE
);

  // Per input: [0],[1] synchroniser stages, [2] previous synchronised level
  logic [2:0] da0_q, da0_d, hs_q, hs_d, fs_q, fs_d;
  logic [15:0] va_q, va_d, rb_q, rb_d;
  logic [DIV_W-1:0] line_q, line_d;
  logic xt_q, xt_d, adv_q, adv_d;

  logic byte_ev, line_ev, field_ev;
  logic mode_lin, mode_x2;
  logic [DIV_W-1:0] ydiv_m1;
  logic [15:0] bpr, base;

  always_comb begin
    da0_d = {da0_q[1:0], DA0};
    hs_d  = {hs_q[1:0], HS_n};
    fs_d  = {fs_q[1:0], FS_n};
  end

  assign byte_ev  = da0_q[1] & ~da0_q[2];
  assign line_ev  = ~hs_q[1] & hs_q[2];
  assign field_ev = ~fs_q[1] & fs_q[2];

  always_comb begin
    mode_lin = 1'b0;
    ydiv_m1  = '0;
    bpr      = 16'd32;
    case (V[2:0])
      3'b000:  begin ydiv_m1 = DIV_W'(11); bpr = 16'd32; end
      3'b001:  begin ydiv_m1 = DIV_W'(2);  bpr = 16'd16; end
      3'b010:  begin ydiv_m1 = DIV_W'(2);  bpr = 16'd32; end
      3'b011:  begin ydiv_m1 = DIV_W'(1);  bpr = 16'd16; end
      3'b100:  begin ydiv_m1 = DIV_W'(1);  bpr = 16'd32; end
      3'b101:  begin ydiv_m1 = DIV_W'(0);  bpr = 16'd16; end
      3'b110:  begin ydiv_m1 = DIV_W'(0);  bpr = 16'd32; end
      default: mode_lin = 1'b1;
    endcase
`ifdef SAM_EXT_VIDEO_EN
    if (V[3]) mode_lin = 1'b1;
    base = V[3] ? {F, 8'h00} : {F[6:0], 9'h000};
`else
    base = {F[6:0], 9'h000};
`endif
    mode_x2 = ~mode_lin & (bpr == 16'd16);
  end

`ifndef SAM_EXT_VIDEO_EN
  logic unused_cfg;
  assign unused_cfg = ^{V[3], F[7]};
`endif

  always_comb begin
    va_d   = va_q;
    rb_d   = rb_q;
    line_d = line_q;
    xt_d   = xt_q;
    adv_d  = 1'b0;
    if (field_ev) begin
      va_d   = base;
      rb_d   = base;
      line_d = '0;
      xt_d   = 1'b0;
    end else if (line_ev) begin
      if (mode_lin) begin
        line_d = '0;
      end else if (line_q >= ydiv_m1) begin
        // >= rather than == so a LINE left over from a larger divide still advances
        rb_d   = rb_q + bpr;
        va_d   = rb_q + bpr;
        line_d = '0;
        xt_d   = 1'b0;
        adv_d  = 1'b1;
      end else begin
        va_d   = rb_q;
        line_d = line_q + DIV_W'(1);
        xt_d   = 1'b0;
      end
    end else if (byte_ev) begin
      if (mode_x2) begin
        xt_d = ~xt_q;
        if (xt_q) va_d = va_q + 16'd1;
      end else begin
        va_d = va_q + 16'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!RESET) begin
      da0_q  <= 3'b000;
      hs_q   <= 3'b111;
      fs_q   <= 3'b111;
      va_q   <= '0;
      rb_q   <= '0;
      line_q <= '0;
      xt_q   <= 1'b0;
      adv_q  <= 1'b0;
    end else begin
      da0_q  <= da0_d;
      hs_q   <= hs_d;
      fs_q   <= fs_d;
      va_q   <= va_d;
      rb_q   <= rb_d;
      line_q <= line_d;
      xt_q   <= xt_d;
      adv_q  <= adv_d;
    end
  end

  assign VA      = va_q;
  assign ROW_ADV = adv_q;
  assign LINE    = line_q;

endmodule
